// File: rtl/operand_fwd_stage.sv
// Issue->EX operand register with EX/MEM bypass and a load-use refill scoreboard.
// Each source operand takes the youngest matching write, the regfile or the immediate.
// If it hits an in-flight load, the operand is marked pending and refilled from MEM later.
module operand_fwd_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NPORT  = 2,
  parameter int unsigned NSRC   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     flush_cause,
  input  logic                     in_delayslot,
  input  logic [3:0]               stall,
  input  logic [NSRC-1:0]          re,
  input  logic [NSRC*ADDR_W-1:0]   raddr,
  input  logic [NSRC*DATA_W-1:0]   rdata,
  input  logic [DATA_W-1:0]        imm,
  input  logic [NPORT-1:0]         ex_we,
  input  logic [NPORT-1:0]         ex_ld,
  input  logic [NPORT*ADDR_W-1:0]  ex_waddr,
  input  logic [NPORT*DATA_W-1:0]  ex_wdata,
  input  logic [NPORT-1:0]         mem_we,
  input  logic [NPORT*ADDR_W-1:0]  mem_waddr,
  input  logic [NPORT*DATA_W-1:0]  mem_wdata,
  output logic [NSRC*DATA_W-1:0]   opnd,
  output logic                     opnd_rdy,
  output logic                     stall_req
);

  // Flush cause and delay-slot encodings of the surrounding pipeline.
  localparam logic CAUSE_EXCEPTION     = 1'b0;
  localparam logic CAUSE_FAILED_BRANCH = 1'b1;
  localparam logic IN_DELAY_SLOT       = 1'b1;

  logic [NSRC-1:0][DATA_W-1:0] data_q, data_d;
  logic [NSRC-1:0][ADDR_W-1:0] saddr_q, saddr_d;
  logic [NSRC-1:0]             pend_q, pend_d;
  logic                        valid_q, valid_d;
  logic [NSRC-1:0][DATA_W-1:0] opnd_d;
  logic                        opnd_rdy_d;
  logic                        stall_req_d;
  logic                        capture;
  logic                        clear_pend;
  logic                        unused_stall;

  // Upper stall bits belong to later stages and are not consumed here.
  assign unused_stall = ^stall[3:2];

  // Next-state: operand select / refill, valid priority chain, and the registered outputs.
  always_comb begin
    capture     = !(stall[0] && stall[1]);
    clear_pend  = 1'b0;
    data_d      = data_q;
    saddr_d     = saddr_q;
    pend_d      = pend_q;
    valid_d     = valid_q;
    opnd_d      = '0;
    opnd_rdy_d  = 1'b0;
    stall_req_d = 1'b0;

    for (int i = 0; i < int'(NSRC); i++) begin
      if (capture) begin
        data_d[i] = rdata[i*DATA_W +: DATA_W];
        pend_d[i] = 1'b0;
        if (!re[i]) begin
          data_d[i] = imm;
        end else if (raddr[i*ADDR_W +: ADDR_W] == '0) begin
          data_d[i] = '0;
        end else begin
          // MEM first, then EX, ascending port order: later assignments are younger and win.
          for (int k = 0; k < int'(NPORT); k++) begin
            if (mem_we[k] && (mem_waddr[k*ADDR_W +: ADDR_W] == raddr[i*ADDR_W +: ADDR_W])) begin
              data_d[i] = mem_wdata[k*DATA_W +: DATA_W];
            end
          end
          for (int k = 0; k < int'(NPORT); k++) begin
            if (ex_we[k] && (ex_waddr[k*ADDR_W +: ADDR_W] == raddr[i*ADDR_W +: ADDR_W])) begin
              if (ex_ld[k]) begin
                data_d[i] = '0;
                pend_d[i] = 1'b1;
              end else begin
                data_d[i] = ex_wdata[k*DATA_W +: DATA_W];
                pend_d[i] = 1'b0;
              end
            end
          end
          if (pend_d[i]) begin
            saddr_d[i] = raddr[i*ADDR_W +: ADDR_W];
          end
        end
      end else if (pend_q[i]) begin
        for (int k = 0; k < int'(NPORT); k++) begin
          if (mem_we[k] && (mem_waddr[k*ADDR_W +: ADDR_W] == saddr_q[i])) begin
            data_d[i] = mem_wdata[k*DATA_W +: DATA_W];
            pend_d[i] = 1'b0;
          end
        end
      end
    end

    if (flush && (flush_cause == CAUSE_EXCEPTION)) begin
      valid_d    = 1'b0;
      clear_pend = 1'b1;
    end else if (flush && (flush_cause == CAUSE_FAILED_BRANCH) && (in_delayslot == IN_DELAY_SLOT)) begin
      valid_d = 1'b1;
    end else if (flush) begin
      valid_d    = 1'b0;
      clear_pend = 1'b1;
    end else if (stall[0] && !stall[1]) begin
      valid_d    = 1'b0;
      clear_pend = 1'b1;
    end else if (!stall[0]) begin
      valid_d = 1'b1;
    end

    if (clear_pend) begin
      pend_d = '0;
    end

    for (int i = 0; i < int'(NSRC); i++) begin
      opnd_d[i] = valid_d ? data_d[i] : '0;
    end
    opnd_rdy_d  = valid_d && !(|pend_d);
    stall_req_d = valid_d && (|pend_d);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q    <= '0;
      saddr_q   <= '0;
      pend_q    <= '0;
      valid_q   <= 1'b0;
      opnd      <= '0;
      opnd_rdy  <= 1'b0;
      stall_req <= 1'b0;
    end else begin
      data_q    <= data_d;
      saddr_q   <= saddr_d;
      pend_q    <= pend_d;
      valid_q   <= valid_d;
      opnd      <= opnd_d;
      opnd_rdy  <= opnd_rdy_d;
      stall_req <= stall_req_d;
    end
  end

endmodule

// File: tb/tb_operand_fwd_stage.sv
// Directed bench for operand_fwd_stage with default parameters (32-bit data, 2 ports, 2 operands).
module tb_operand_fwd_stage;

  localparam logic EXC = 1'b0;
  localparam logic FBP = 1'b1;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        flush_cause;
  logic        in_delayslot;
  logic [3:0]  stall;
  logic [1:0]  re;
  logic [9:0]  raddr;
  logic [63:0] rdata;
  logic [31:0] imm;
  logic [1:0]  ex_we;
  logic [1:0]  ex_ld;
  logic [9:0]  ex_waddr;
  logic [63:0] ex_wdata;
  logic [1:0]  mem_we;
  logic [9:0]  mem_waddr;
  logic [63:0] mem_wdata;
  logic [63:0] opnd;
  logic        opnd_rdy;
  logic        stall_req;

  int checks = 0;
  int errors = 0;

  operand_fwd_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .flush_cause(flush_cause),
    .in_delayslot(in_delayslot), .stall(stall), .re(re), .raddr(raddr),
    .rdata(rdata), .imm(imm), .ex_we(ex_we), .ex_ld(ex_ld),
    .ex_waddr(ex_waddr), .ex_wdata(ex_wdata), .mem_we(mem_we),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .opnd(opnd),
    .opnd_rdy(opnd_rdy), .stall_req(stall_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; flush_cause = EXC; in_delayslot = 1'b0; stall = 4'b0000;
    re = 2'b00; raddr = '0; rdata = '0; imm = '0;
    ex_we = '0; ex_ld = '0; ex_waddr = '0; ex_wdata = '0;
    mem_we = '0; mem_waddr = '0; mem_wdata = '0;

    // 1: reset, then immediate capture on both operands
    step(); step();
    check("rst_opnd", opnd, 64'h0);
    check("rst_rdy", {63'h0, opnd_rdy}, 64'h0);
    check("rst_sreq", {63'h0, stall_req}, 64'h0);
    rst = 1'b0; imm = 32'h1234;
    step();
    check("imm_opnd", opnd, 64'h0000_1234_0000_1234);
    check("imm_rdy", {63'h0, opnd_rdy}, 64'h1);

    // 2: youngest EX port beats older EX port and MEM
    re = 2'b01; raddr = {5'd0, 5'd5}; rdata = {32'h0, 32'h55};
    ex_we = 2'b11; ex_waddr = {5'd5, 5'd5}; ex_wdata = {32'hB, 32'hA};
    mem_we = 2'b10; mem_waddr = {5'd5, 5'd0}; mem_wdata = {32'hC, 32'h0};
    step();
    check("ex_young", opnd, 64'h0000_1234_0000_000B);
    ex_we = 2'b00;
    step();
    check("mem_fwd", opnd[31:0], 64'hC);
    mem_we = 2'b00;
    step();
    check("rf_read", opnd[31:0], 64'h55);

    // 3: $0 never bypassed, rdata ignored
    raddr = {5'd0, 5'd0}; rdata = {32'h0, 32'h77};
    ex_we = 2'b01; ex_waddr = {5'd0, 5'd0}; ex_wdata = {32'h0, 32'hFF};
    step();
    check("zero_reg", opnd[31:0], 64'h0);
    ex_we = 2'b00;

    // 4: load-use pend, then refill under full hold
    raddr = {5'd0, 5'd7};
    ex_we = 2'b10; ex_ld = 2'b10; ex_waddr = {5'd7, 5'd0}; ex_wdata = {32'h99, 32'h0};
    step();
    check("ld_opnd", opnd[31:0], 64'h0);
    check("ld_sreq", {63'h0, stall_req}, 64'h1);
    check("ld_rdy", {63'h0, opnd_rdy}, 64'h0);
    stall = 4'b0011; ex_we = 2'b00; ex_ld = 2'b00;
    mem_we = 2'b10; mem_waddr = {5'd7, 5'd0}; mem_wdata = {32'hDEAD, 32'h0};
    step();
    check("refill_opnd", opnd, 64'h0000_1234_0000_DEAD);
    check("refill_sreq", {63'h0, stall_req}, 64'h0);
    check("refill_rdy", {63'h0, opnd_rdy}, 64'h1);
    mem_we = 2'b00;

    // 5: bubble, delay-slot keep, mispredict kill
    stall = 4'b0001;
    step();
    check("bubble_opnd", opnd, 64'h0);
    check("bubble_rdy", {63'h0, opnd_rdy}, 64'h0);
    stall = 4'b0000; raddr = {5'd0, 5'd3}; rdata = {32'h0, 32'h333};
    flush = 1'b1; flush_cause = FBP; in_delayslot = 1'b1;
    step();
    check("ds_keep", opnd[31:0], 64'h333);
    check("ds_rdy", {63'h0, opnd_rdy}, 64'h1);
    in_delayslot = 1'b0; rdata = {32'h0, 32'h444};
    step();
    check("mispred_kill", opnd, 64'h0);
    flush = 1'b0;
    step();
    check("after_kill", opnd[31:0], 64'h444);

    // 6: exception flush clears pend, then normal capture and a plain hold
    raddr = {5'd0, 5'd9};
    ex_we = 2'b01; ex_ld = 2'b01; ex_waddr = {5'd0, 5'd9}; ex_wdata = '0;
    step();
    check("pend9_sreq", {63'h0, stall_req}, 64'h1);
    flush = 1'b1; flush_cause = EXC; stall = 4'b0011;
    step();
    check("exc_sreq", {63'h0, stall_req}, 64'h0);
    check("exc_opnd", opnd, 64'h0);
    check("exc_rdy", {63'h0, opnd_rdy}, 64'h0);
    flush = 1'b0; stall = 4'b0000; ex_we = 2'b00; ex_ld = 2'b00; rdata = {32'h0, 32'h999};
    step();
    check("post_exc", opnd[31:0], 64'h999);
    check("post_exc_rdy", {63'h0, opnd_rdy}, 64'h1);
    stall = 4'b0011; rdata = {32'h0, 32'h111}; imm = 32'h5678;
    step();
    check("hold", opnd, 64'h0000_1234_0000_0999);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
